// File: rtl/dino_pkg.sv
// Shared game constants: state/type/behaviour codes and sprite geometry.
// Used by the object controller, renderer and collision/score block.
package dino_pkg;

  typedef enum logic [1:0] {
    GS_INIT  = 2'd0,
    GS_START = 2'd1,
    GS_END   = 2'd2,
    GS_RESET = 2'd3
  } game_state_e;

  typedef enum logic [2:0] {
    LOW_BIRD  = 3'd0,
    HIGH_BIRD = 3'd1,
    SMALL     = 3'd2,
    MANY      = 3'd3,
    BIG       = 3'd4,
    NOTHING   = 3'd5
  } danger_e;

  typedef enum logic {
    SIT   = 1'b0,
    STAND = 1'b1
  } dino_beh_e;

  localparam int GROUND        = 400;

  localparam int STAND_W       = 44;
  localparam int STAND_H       = 47;
  localparam int SIT_W         = 59;
  localparam int SIT_H         = 30;

  localparam int BIRD_W        = 44;
  localparam int BIRD_H        = 33;
  localparam int LOW_BIRD_OFF  = 32;
  localparam int HIGH_BIRD_OFF = 60;

  localparam int SMALL_W       = 19;
  localparam int SMALL_H       = 36;
  localparam int MANY_W        = 77;
  localparam int MANY_H        = 49;
  localparam int BIG_W         = 27;
  localparam int BIG_H         = 50;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit packed-BCD counter with synchronous clear and
// saturation at 9999.
module bcd_counter4 (
  input  logic        game_clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] q
);

  logic [15:0] nxt;
  logic        carry;

  always_comb begin
    nxt   = q;
    carry = (q != 16'h9999);
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (q[i*4 +: 4] == 4'd9) begin
          nxt[i*4 +: 4] = 4'd0;
        end else begin
          nxt[i*4 +: 4] = q[i*4 +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge game_clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/dino_hit_score.sv
// Dino vs danger-slot collision pipeline, post-restart blanking,
// running BCD score and session high score.
module dino_hit_score #(
  parameter int DINO_X       = 60,
  parameter int GROUND       = dino_pkg::GROUND,
  parameter int SCORE_DIV    = 16,
  parameter int BLANK_CYCLES = 64
) (
  input  logic        game_clk,
  input  logic        rst,
  input  logic [1:0]  game_state,
  input  logic [9:0]  dino_pos,
  input  logic        dino_behavior,
  input  logic [9:0]  danger_pos1,
  input  logic [9:0]  danger_pos2,
  input  logic [9:0]  danger_pos3,
  input  logic [2:0]  danger_type1,
  input  logic [2:0]  danger_type2,
  input  logic [2:0]  danger_type3,
  input  logic        danger_en1,
  input  logic        danger_en2,
  input  logic        danger_en3,
  output logic        isColision,
  output logic [1:0]  hit_slot,
  output logic [15:0] score,
  output logic [15:0] high_score
);
  import dino_pkg::*;

  localparam int DW = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam int BW = $clog2(BLANK_CYCLES + 1);

  // Y ranges are half-open (top, bottom]; rearranged to avoid underflow.
  function automatic logic slot_hit(
    input logic [9:0] pos,
    input logic [2:0] typ,
    input logic       en,
    input logic [9:0] dy,
    input logic       beh
  );
    logic [10:0] g, dx, p, y, dw, dh, w, c, d, l;
    danger_e     t;
    g  = 11'(GROUND);
    dx = 11'(DINO_X);
    p  = {1'b0, pos};
    y  = {1'b0, dy};
    t  = danger_e'(typ);
    dw = (beh == STAND) ? 11'(STAND_W) : 11'(SIT_W);
    dh = (beh == STAND) ? 11'(STAND_H) : 11'(SIT_H);
    w  = '0;
    c  = '0;
    d  = '0;
    unique case (t)
      LOW_BIRD: begin
        w = 11'(BIRD_W);
        c = g - 11'(LOW_BIRD_OFF + BIRD_H);
        d = g - 11'(LOW_BIRD_OFF);
      end
      HIGH_BIRD: begin
        w = 11'(BIRD_W);
        c = g - 11'(HIGH_BIRD_OFF + BIRD_H);
        d = g - 11'(HIGH_BIRD_OFF);
      end
      SMALL: begin
        w = 11'(SMALL_W);
        c = g - 11'(SMALL_H);
        d = g;
      end
      MANY: begin
        w = 11'(MANY_W);
        c = g - 11'(MANY_H);
        d = g;
      end
      BIG: begin
        w = 11'(BIG_W);
        c = g - 11'(BIG_H);
        d = g;
      end
      default: begin
        w = '0;
        c = '0;
        d = '0;
      end
    endcase
    l = (p < w) ? 11'd0 : p - w;
    return en && (typ < 3'd5)
        && (dx < p) && (l < dx + dw)
        && (c < y) && (y < d + dh);
  endfunction

  game_state_e     st, prev_st;
  logic            restart, in_start, in_end_first;
  logic [2:0]      hit_now, h;
  logic [BW-1:0]   blank;
  logic [DW-1:0]   div;
  logic            div_wrap, score_inc;

  assign st           = game_state_e'(game_state);
  assign in_start     = (st == GS_START);
  assign restart      = in_start && (prev_st != GS_START);
  assign in_end_first = (st == GS_END) && (prev_st != GS_END);

  always_comb begin
    hit_now    = '0;
    hit_now[0] = slot_hit(danger_pos1, danger_type1, danger_en1,
                          dino_pos, dino_behavior);
    hit_now[1] = slot_hit(danger_pos2, danger_type2, danger_en2,
                          dino_pos, dino_behavior);
    hit_now[2] = slot_hit(danger_pos3, danger_type3, danger_en3,
                          dino_pos, dino_behavior);
  end

  always_ff @(posedge game_clk or posedge rst) begin
    if (rst) begin
      prev_st <= GS_INIT;
    end else begin
      prev_st <= st;
    end
  end

  always_ff @(posedge game_clk or posedge rst) begin
    if (rst) begin
      blank <= '0;
    end else if (restart) begin
      blank <= BW'(BLANK_CYCLES);
    end else if (in_start && blank != '0) begin
      blank <= blank - 1'b1;
    end
  end

  always_ff @(posedge game_clk or posedge rst) begin
    if (rst) begin
      h <= '0;
    end else if (restart) begin
      h <= '0;
    end else if (in_start && blank == '0) begin
      h <= hit_now;
    end else begin
      h <= '0;
    end
  end

  always_ff @(posedge game_clk or posedge rst) begin
    if (rst) begin
      isColision <= 1'b0;
      hit_slot   <= 2'd0;
    end else if (restart) begin
      isColision <= 1'b0;
      hit_slot   <= 2'd0;
    end else if (h != '0 && !isColision) begin
      isColision <= 1'b1;
      priority case (1'b1)
        h[0]:    hit_slot <= 2'd1;
        h[1]:    hit_slot <= 2'd2;
        default: hit_slot <= 2'd3;
      endcase
    end
  end

  assign div_wrap  = (div == DW'(SCORE_DIV - 1));
  assign score_inc = in_start && !isColision && div_wrap;

  always_ff @(posedge game_clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (restart) begin
      div <= '0;
    end else if (in_start && !isColision) begin
      div <= div_wrap ? '0 : div + 1'b1;
    end
  end

  bcd_counter4 u_score (
    .game_clk (game_clk),
    .rst      (rst),
    .clr      (restart),
    .inc      (score_inc),
    .q        (score)
  );

  // Packed BCD orders the same as its binary value.
  always_ff @(posedge game_clk or posedge rst) begin
    if (rst) begin
      high_score <= '0;
    end else if (in_end_first && score > high_score) begin
      high_score <= score;
    end
  end

endmodule

// File: tb/tb_dino_hit_score.sv
// Scoreboard bench for dino_hit_score: collision geometry, latency,
// blanking, BCD score saturation, high score and async reset.
module tb_dino_hit_score;

  localparam int SDIV = 4;

  localparam int K_COL  = 0;
  localparam int K_SLOT = 1;
  localparam int K_SCR  = 2;
  localparam int K_HIGH = 3;

  typedef struct {
    string       tag;
    int          kind;
    logic [15:0] exp;
  } sb_t;

  logic        game_clk;
  logic        rst;
  logic [1:0]  game_state;
  logic [9:0]  dino_pos;
  logic        dino_behavior;
  logic [9:0]  danger_pos1, danger_pos2, danger_pos3;
  logic [2:0]  danger_type1, danger_type2, danger_type3;
  logic        danger_en1, danger_en2, danger_en3;
  logic        isColision;
  logic [1:0]  hit_slot;
  logic [15:0] score, high_score;

  sb_t sb[$];
  int  n_chk;
  int  n_fail;

  dino_hit_score #(
    .SCORE_DIV (SDIV)
  ) u_dut (
    .game_clk      (game_clk),
    .rst           (rst),
    .game_state    (game_state),
    .dino_pos      (dino_pos),
    .dino_behavior (dino_behavior),
    .danger_pos1   (danger_pos1),
    .danger_pos2   (danger_pos2),
    .danger_pos3   (danger_pos3),
    .danger_type1  (danger_type1),
    .danger_type2  (danger_type2),
    .danger_type3  (danger_type3),
    .danger_en1    (danger_en1),
    .danger_en2    (danger_en2),
    .danger_en3    (danger_en3),
    .isColision    (isColision),
    .hit_slot      (hit_slot),
    .score         (score),
    .high_score    (high_score)
  );

  initial game_clk = 1'b0;
  always #5 game_clk = ~game_clk;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int kind,
                      input logic [15:0] exp);
    sb_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    sb_t         e;
    logic [15:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_COL:   act = {15'd0, isColision};
        K_SLOT:  act = {14'd0, hit_slot};
        K_SCR:   act = score;
        default: act = high_score;
      endcase
      check(e.tag, act, e.exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge game_clk);
  endtask

  task automatic clear_slots();
    danger_en1 = 0; danger_type1 = 3'd5; danger_pos1 = '0;
    danger_en2 = 0; danger_type2 = 3'd5; danger_pos2 = '0;
    danger_en3 = 0; danger_type3 = 3'd5; danger_pos3 = '0;
  endtask

  task automatic set_slot(input int i, input logic [2:0] t,
                          input logic [9:0] p);
    case (i)
      1: begin danger_en1 = 1; danger_type1 = t; danger_pos1 = p; end
      2: begin danger_en2 = 1; danger_type2 = t; danger_pos2 = p; end
      default: begin
        danger_en3 = 1; danger_type3 = t; danger_pos3 = p;
      end
    endcase
  endtask

  // END then START; returns 66 ticks after the restart edge.
  task automatic restart_game();
    game_state = 2'd2;
    tick(1);
    game_state = 2'd1;
    tick(67);
  endtask

  task automatic expect_none(input string tag);
    tick(3);
    push(tag, K_COL, 16'd0);
    drain();
    clear_slots();
    dino_pos      = 10'd400;
    dino_behavior = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst           = 1'b1;
    game_state    = 2'd0;
    dino_pos      = 10'd400;
    dino_behavior = 1'b1;
    clear_slots();
    tick(2);
    push("rst_col", K_COL, 16'd0);
    push("rst_slot", K_SLOT, 16'd0);
    push("rst_score", K_SCR, 16'd0);
    push("rst_high", K_HIGH, 16'd0);
    drain();
    rst = 1'b0;
    tick(1);

    restart_game();
    dino_behavior = 1'b0;
    set_slot(1, 3'd0, 10'd100);
    expect_none("sit_low_bird");
    set_slot(1, 3'd1, 10'd100);
    expect_none("stand_high_bird");
    set_slot(1, 3'd2, 10'd60);
    expect_none("small_pos60");
    set_slot(1, 3'd4, 10'd10);
    expect_none("big_pos10");
    set_slot(1, 3'd7, 10'd100);
    expect_none("type7_nothing");
    set_slot(2, 3'd2, 10'd61);
    danger_en2 = 1'b0;
    expect_none("slot_disabled");

    dino_pos = 10'd350;
    set_slot(1, 3'd1, 10'd100);
    tick(1);
    push("jump_lat1", K_COL, 16'd0);
    drain();
    tick(1);
    push("jump_high_col", K_COL, 16'd1);
    push("jump_high_slot", K_SLOT, 16'd1);
    drain();
    clear_slots();
    dino_pos = 10'd400;

    restart_game();
    push("restart_col", K_COL, 16'd0);
    push("restart_slot", K_SLOT, 16'd0);
    drain();
    set_slot(1, 3'd2, 10'd61);
    tick(2);
    push("small_pos61", K_COL, 16'd1);
    drain();
    clear_slots();

    restart_game();
    set_slot(1, 3'd0, 10'd100);
    tick(1);
    clear_slots();
    tick(1);
    push("low_bird_held", K_COL, 16'd1);
    push("low_bird_slot", K_SLOT, 16'd1);
    drain();

    restart_game();
    set_slot(2, 3'd2, 10'd61);
    set_slot(3, 3'd0, 10'd100);
    tick(2);
    push("two_slot_col", K_COL, 16'd1);
    push("two_slot_slot", K_SLOT, 16'd2);
    drain();
    game_state = 2'd2;
    tick(1);
    game_state = 2'd1;
    tick(1);
    push("clr_col", K_COL, 16'd0);
    push("clr_slot", K_SLOT, 16'd0);
    push("clr_score", K_SCR, 16'd0);
    drain();
    tick(64);
    push("blank_64", K_COL, 16'd0);
    drain();
    tick(1);
    push("blank_65", K_COL, 16'd0);
    drain();
    tick(1);
    push("blank_done_col", K_COL, 16'd1);
    push("blank_done_slot", K_SLOT, 16'd2);
    drain();
    clear_slots();

    restart_game();
    push("score_16", K_SCR, 16'h0016);
    drain();
    tick(SDIV * 9999 + 40);
    push("score_sat", K_SCR, 16'h9999);
    drain();
    game_state = 2'd2;
    tick(1);
    push("high_9999", K_HIGH, 16'h9999);
    drain();
    game_state = 2'd1;
    tick(1);
    tick(SDIV * 5);
    push("score_5", K_SCR, 16'h0005);
    drain();
    game_state = 2'd2;
    tick(3);
    push("high_kept", K_HIGH, 16'h9999);
    push("score_end_hold", K_SCR, 16'h0005);
    drain();

    game_state = 2'd1;
    tick(1);
    tick(490);
    set_slot(1, 3'd2, 10'd61);
    tick(2);
    push("pre_rst_col", K_COL, 16'd1);
    push("pre_rst_score", K_SCR, 16'h0123);
    drain();
    tick(3);
    push("score_frozen", K_SCR, 16'h0123);
    drain();
    @(posedge game_clk);
    #2 rst = 1'b1;
    #1;
    push("async_col", K_COL, 16'd0);
    push("async_slot", K_SLOT, 16'd0);
    push("async_score", K_SCR, 16'd0);
    push("async_high", K_HIGH, 16'd0);
    drain();
    tick(1);
    rst = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dino_hit_score.md
# dino_hit_score

Downstream consumer of the object controller: each `game_clk` tick it checks the dino bounding box against the three danger slots and drives `isColision` back into the game-state logic. It also keeps the running score and the session high score for the display path. It is a two-stage registered pipeline plus a post-restart blanking counter and a BCD score counter.

## Interface
Parameters:
- `DINO_X`, 60: fixed left x of the dino, in pixels.
- `GROUND`, 400: y of the ground line; the dino's feet rest here.
- `SCORE_DIV`, 16: `game_clk` ticks per score increment.
- `BLANK_CYCLES`, 64: collision-ignore window after a restart.

Ports:
- `game_clk` in 1: block clock.
- `rst` in 1: asynchronous, active-high reset.
- `game_state` in 2: INIT=0, START=1, END=2, RESET=3.
- `dino_pos` in 10: dino bottom y. Smaller means higher.
- `dino_behavior` in 1: SIT=0, STAND=1.
- `danger_pos1..3` in 10 each: right-edge x of each slot.
- `danger_type1..3` in 3 each: LOW_BIRD=0, HIGH_BIRD=1, SMALL=2, MANY=3, BIG=4, NOTHING=5.
- `danger_en1..3` in 1 each: slot valid.
- `isColision` out 1: collision latched.
- `hit_slot` out 2: slot that caused the hit (1..3); 0 means none.
- `score` out 16: 4-digit packed BCD.
- `high_score` out 16: 4-digit packed BCD.

## Operation
- **Restart event:** `game_state`==START while the registered previous state was INIT, END or RESET. On a restart:
  - `score` goes to 0.
  - `isColision` clears and `hit_slot` goes to 0.
  - The blank counter loads `BLANK_CYCLES`.
  - The stage-1 hit bits clear.
- **Dino box:** x in [DINO_X, DINO_X+W), y in (dino_pos−H, dino_pos].
  - STAND: W=44, H=47.
  - SIT: W=59, H=30.
- **Danger box:** x in [max(pos−w,0), pos). Compute `pos < w` in 11-bit arithmetic before subtracting; on underflow, left = 0.
- **Danger y ranges and widths:**
  - Cactus: (GROUND−h, GROUND]. SMALL is w19/h36, MANY is w77/h49, BIG is w27/h50.
  - LOW_BIRD: (GROUND−65, GROUND−32], w44.
  - HIGH_BIRD: (GROUND−93, GROUND−60], w44.
- **Overlap test:** strict on half-open intervals (`aL < bR && bL < aR`) on both axes.
- **Slot masking:** a slot with `en`=0 or type NOTHING never hits. Type codes 6 and 7 behave as NOTHING.
- **Stage 1:** registers hit bits h1..h3. They are nonzero only when state==START and the blank counter is 0.
- **Stage 2:** if any h bit is set and `isColision`=0, set `isColision`=1 and set `hit_slot` to the lowest-index set bit. The latch holds until a restart or `rst`.
- **Blank counter:** decrements once per tick in START while nonzero. It holds in every other state.
- **Score:**
  - A divider counts 0..SCORE_DIV−1 in START, while `isColision`=0.
  - `score` gets BCD +1 on the wrap. It saturates at 9999.
  - Divider and score hold in INIT and END.
- **High score:** on the first tick of END (previous state ≠ END), `high_score` ← `score` if `score` > `high_score`. Plain unsigned compare is valid on packed BCD. `high_score` is cleared only by `rst`.

## Timing
- All state updates on posedge `game_clk`.
- **Reset values:** `isColision` 0, `hit_slot` 0, `score` 0, `high_score` 0, h1..h3 0, blank counter 0, divider 0, previous state INIT.
- **Collision latency:** overlap sampled at edge N, `isColision` high after edge N+1 (2 ticks). Position changes between N and N+1 do not cancel a registered hit.
- **Score and restart:** a score increment and a restart on the same tick resolve to 0 (restart wins).
- **Simultaneous hits:** two slots hitting on the same tick report the lower index.
- **Reset mid-operation:** asserting `rst` during a latched collision clears everything immediately, asynchronously.

## Structure
- Shared package `dino_pkg` holds:
  - Type codes, game-state codes, dino behaviour codes.
  - Sprite width/height constants and `GROUND`.
  - Bird y offsets (32, 60).
- Shared by ObjCtrl and the renderer.
- One sub-module, `bcd_counter4`: 4-digit packed-BCD incrementer with `clr`/`inc`/saturate.
- Per-slot overlap logic is a function (or generate loop) instantiated ×3.

## Test plan
- **Standing vs low bird:** `dino_pos`=400 STAND, slot1 LOW_BIRD pos=100 en=1, state START, blank expired -> `isColision`=1, `hit_slot`=1 two ticks later.
- **Sitting vs low bird:** same as above with SIT -> no collision (sit top 370 is below bird bottom 368). **Standing vs high bird:** `dino_pos`=400 STAND, HIGH_BIRD -> no collision. **Jumping vs high bird:** `dino_pos`=350, HIGH_BIRD -> hit.
- **Edge cases:** SMALL_CACTUS pos=60 (right edge = DINO_X) -> no hit; pos=61 -> hit. BIG pos=10 exercises the left clamp at 0 without false hit.
- **Two-slot hit and clear:** slot2 and slot3 hit on the same tick -> `hit_slot`=2. Then END→START -> `isColision` 0, `score` 0, and no hit for 64 ticks despite overlap.
- **Score:** 16·9999+40 START ticks -> `score`=0x9999 held. Enter END -> `high_score`=0x9999. Restart, run to score 5, END -> `high_score` stays 0x9999.
- **Reset:** `rst` pulse mid-game with `isColision`=1 and score 0x0123 -> all outputs 0 asynchronously.
